// File: rtl/sync_hs_pkg.sv
// Shared definitions for the toggle-handshake receiver: FSM state type,
// synchronizer depth floor and statistics counter width.
package sync_hs_pkg;

   localparam int unsigned MIN_SYNC_DEPTH = 2;
   localparam int unsigned XFER_CNT_W     = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      ACK  = 2'd2
   } state_e;

endpackage

// File: rtl/sync_handshake_rx_syncregs.sv
// syncregs: DEPTH-stage flop chain bringing an asynchronous bus into clk_i.
// Every stage clears on the synchronous active-high reset.
module syncregs #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   // Shift the asynchronous input through the metastability chain
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sync_handshake_rx.sv
// sync_handshake_rx: receive side of a toggle req/ack clock-domain crossing.
// A synchronized request toggle captures the held payload into dout; once the
// consumer takes it, ack_tgl flips back to the sender.
// Optional feature: define SYNC_HANDSHAKE_RX_STATS_EN to add the saturating
// 16-bit xfer_count output.
module sync_handshake_rx
   import sync_hs_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned SYNC_DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_tgl_async,
   input  logic [WIDTH-1:0] data_async,
   output logic             ack_tgl,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             proto_err
`ifdef SYNC_HANDSHAKE_RX_STATS_EN
   ,
   output logic [XFER_CNT_W-1:0] xfer_count
`endif
);

   if (SYNC_DEPTH < MIN_SYNC_DEPTH) begin : g_depth_check
      $error("sync_handshake_rx: SYNC_DEPTH must be at least MIN_SYNC_DEPTH");
   end

   state_e           state_q, state_d;
   logic             req_sync;
   logic             req_seen_q, req_seen_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             ack_q, ack_d;
   logic             perr_q, perr_d;
   logic             pending;
   logic             load_en;
   logic             xfer_en;

   syncregs #(
      .WIDTH (1),
      .DEPTH (SYNC_DEPTH)
   ) u_req_sync (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (req_tgl_async),
      .q_o   (req_sync)
   );

   assign pending = (req_sync != req_seen_q);
   assign load_en = (state_q == IDLE) && pending;
   assign xfer_en = (state_q == HOLD) && valid_q && dout_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: capture, wait for consumer, one-cycle ack phase
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pending) state_d = HOLD;
         HOLD:    if (valid_q && dout_ready) state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values derived from the current state
   always_comb begin
      dout_d     = dout_q;
      valid_d    = valid_q;
      req_seen_d = req_seen_q;
      ack_d      = ack_q;
      perr_d     = perr_q;
      if (load_en) begin
         dout_d     = data_async;
         valid_d    = 1'b1;
         req_seen_d = req_sync;
      end
      if (xfer_en) begin
         valid_d = 1'b0;
         ack_d   = ~ack_q;
      end
      // req_seen equals req_sync from capture onward, so any difference
      // outside IDLE is a sender toggle that arrived before our ack
      if ((state_q != IDLE) && pending) begin
         perr_d = 1'b1;
      end
   end

   // Datapath and handshake registers
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q     <= '0;
         valid_q    <= 1'b0;
         req_seen_q <= 1'b0;
         ack_q      <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         dout_q     <= dout_d;
         valid_q    <= valid_d;
         req_seen_q <= req_seen_d;
         ack_q      <= ack_d;
         perr_q     <= perr_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign ack_tgl    = ack_q;
   assign proto_err  = perr_q;
   assign busy       = (state_q != IDLE);

`ifdef SYNC_HANDSHAKE_RX_STATS_EN
   logic [XFER_CNT_W-1:0] xfer_cnt_q;

   // Count ack toggles, holding at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_cnt_q <= '0;
      end else if (xfer_en && (xfer_cnt_q != '1)) begin
         xfer_cnt_q <= xfer_cnt_q + 1'b1;
      end
   end

   assign xfer_count = xfer_cnt_q;
`endif

endmodule

// File: doc/sync_handshake_rx.md
SYNC_HANDSHAKE_RX -- requirements
Module: sync_handshake_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data bus width in bits.
REQ-002 SHALL have parameter SYNC_DEPTH, default 3, minimum 2: number of synchronizer stages on the request toggle.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic is sampled on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_tgl_async, input, 1 bit: request toggle from the sending domain, asynchronous to clk.
REQ-006 SHALL have port data_async, input, WIDTH bits: payload from the sender, held stable from the req toggle until the matching ack toggle.
REQ-007 SHALL have port ack_tgl, output, 1 bit: acknowledge toggle back to the sender.
REQ-008 SHALL have port dout, output, WIDTH bits: captured payload.
REQ-009 SHALL have port dout_valid, output, 1 bit: dout holds an untaken word.
REQ-010 SHALL have port dout_ready, input, 1 bit: the consumer accepts dout this cycle.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port proto_err, output, 1 bit: sticky flag for a protocol violation.

Function
REQ-013 SHALL synchronize req_tgl_async through SYNC_DEPTH flops; the result is req_sync.
REQ-014 SHALL keep register req_seen; a request is pending when req_sync != req_seen.
REQ-015 SHALL use the FSM states IDLE, HOLD and ACK, encoded as a 2-bit enum.
REQ-016 SHALL, in IDLE with a request pending at cycle T, at T+1 load dout from data_async, set dout_valid=1, set req_seen=req_sync and enter HOLD.
REQ-017 SHALL, in HOLD, keep dout and dout_valid unchanged until dout_valid && dout_ready.
REQ-018 SHALL, on the cycle after the transfer, clear dout_valid, invert ack_tgl and enter ACK.
REQ-019 SHALL return from ACK to IDLE after exactly one cycle; a request pending in ACK is serviced from IDLE on the next cycle.
REQ-020 SHALL apply no combinational path from dout_ready to dout_valid.
REQ-021 SHALL treat dout_ready high in the cycle dout_valid rises as a transfer at T+1 and toggle ack_tgl at T+2.
REQ-022 SHALL set proto_err when req_sync changes while in HOLD or ACK.
REQ-023 SHALL keep proto_err set until rst, and SHALL NOT alter the in-flight transfer when setting it.
REQ-024 SHALL drive ack_tgl directly from a flop with no glitch-capable logic after it.

Reset
REQ-025 SHALL, on rst, set state=IDLE, dout=0, dout_valid=0, ack_tgl=0, req_seen=0, proto_err=0 and all synchronizer stages to 0.
REQ-026 SHALL, on rst asserted mid-transfer, abandon the word without toggling ack_tgl; the sender is reset in the same reset domain.
REQ-027 SHALL give rst priority over every other event in the same cycle.

Configuration
REQ-028 SHALL, with macro SYNC_HANDSHAKE_RX_STATS_EN defined, add output xfer_count (16 bits) that increments on each ack toggle, saturates at 16'hFFFF and resets to 0.
REQ-029 SHALL, without SYNC_HANDSHAKE_RX_STATS_EN, omit the xfer_count port and counter entirely, with all other behaviour identical.

Structure
REQ-030 SHALL define the FSM state enum and the constant MIN_SYNC_DEPTH=2 in shared package sync_hs_pkg.
REQ-031 SHALL instantiate the existing syncregs block (WIDTH=1, DEPTH=SYNC_DEPTH) as its only sub-module, for req_sync.
REQ-032 SHALL raise an elaboration error if SYNC_DEPTH < MIN_SYNC_DEPTH.

Verification
REQ-033 SHALL cover: req toggles 0->1 with data 32'hDEADBEEF and dout_ready=1 -> dout=32'hDEADBEEF valid SYNC_DEPTH+1 cycles after the toggle; ack_tgl=1 one cycle after the transfer.
REQ-034 SHALL cover: dout_ready=0 for 10 cycles after valid -> dout and dout_valid stable for all 10 cycles, and ack_tgl unchanged until after the transfer.
REQ-035 SHALL cover: 4 back-to-back transfers (sender toggles on each ack) -> 4 words in order, ack_tgl ends at 0, proto_err=0, and xfer_count=4 when the stats macro is enabled.
REQ-036 SHALL cover: a second req toggle while in HOLD -> proto_err=1 and the first word still delivered intact.
REQ-037 SHALL cover: rst in HOLD -> next cycle dout_valid=0, ack_tgl=0, state IDLE, proto_err=0.
REQ-038 SHALL cover: xfer_count preloaded at 16'hFFFE followed by 3 transfers -> xfer_count=16'hFFFF.
